// File: rtl/trng_word_collector_if.sv
// Bundle of the sampling inputs and the word output handshake.
// valid/ready rule: a word transfers on a posedge where valid_o and ready_i
// are both high; valid_o never depends on ready_i, and word_o is 0 while
// valid_o is low.
interface trng_word_collector_if #(
  parameter int NBITS = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) ();
  logic                       en_i;
  logic [NCH-1:0]             bits_i;
  logic                       xor_mode_i;
  logic [NBITS-1:0]           word_o;
  logic                       valid_o;
  logic                       ready_i;
  logic [$clog2(DEPTH+1)-1:0] fill_o;
  logic                       overflow_o;

  // Collector side
  modport master (
    input  en_i, bits_i, xor_mode_i, ready_i,
    output word_o, valid_o, fill_o, overflow_o
  );

  // Sampler / consumer side
  modport slave (
    output en_i, bits_i, xor_mode_i, ready_i,
    input  word_o, valid_o, fill_o, overflow_o
  );
endinterface

// File: rtl/trng_word_collector.sv
// Entropy word collector: shifts raw or XOR-folded entropy bits into an
// NBITS accumulator and queues each completed word in a DEPTH-entry FIFO.
module trng_word_collector #(
  parameter int NBITS = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_i,
  trng_word_collector_if.master bus
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  // Reject illegal parameter combinations at elaboration
  if (NBITS < 2 || NCH < 1 || (NBITS % NCH) != 0 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("trng_word_collector: illegal NBITS/NCH/DEPTH combination");
  end

  logic [NBITS-1:0]     acc;
  logic [CW-1:0]        count;
  logic                 mode_q;
  logic [NBITS-1:0]     mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [FW-1:0]        fill;
  logic                 overflow;

  logic                 mode_change;
  logic                 sample;
  logic [NBITS+NCH-1:0] raw_cat;
  logic [NBITS:0]       xor_cat;
  logic [NBITS-1:0]     acc_next;
  logic [CW-1:0]        step;
  logic [CW-1:0]        count_sum;
  logic                 complete;
  logic                 valid;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  // Next accumulator value, word completion and FIFO push/pop decisions
  always_comb begin
    mode_change = bus.xor_mode_i != mode_q;
    sample      = bus.en_i && !mode_change;
    // Concatenate then truncate so NCH == NBITS needs no special case
    raw_cat     = {acc, bus.bits_i};
    xor_cat     = {acc, ^bus.bits_i};
    acc_next    = mode_q ? xor_cat[NBITS-1:0] : raw_cat[NBITS-1:0];
    step        = mode_q ? CW'(1) : CW'(NCH);
    count_sum   = count + step;
    complete    = sample && (count_sum == CW'(NBITS));
    valid       = fill != '0;
    full        = fill == FW'(DEPTH);
    pop         = valid && bus.ready_i;
    push        = complete && (!full || pop);
    drop        = complete && full && !pop;
  end

  // Accumulator, bit count and registered sampling mode
  always_ff @(posedge clk) begin
    if (rst_i) begin
      acc    <= '0;
      count  <= '0;
      mode_q <= bus.xor_mode_i;
    end else if (mode_change) begin
      // A mode switch abandons the partial word and this cycle's sample
      acc    <= '0;
      count  <= '0;
      mode_q <= bus.xor_mode_i;
    end else if (sample) begin
      acc   <= acc_next;
      count <= complete ? '0 : count_sum;
    end
  end

  // FIFO storage; contents are only meaningful below the fill level
  always_ff @(posedge clk) begin
    if (!rst_i && push) begin
      mem[wr_ptr] <= acc_next;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign bus.valid_o    = valid;
  assign bus.word_o     = valid ? mem[rd_ptr] : '0;
  assign bus.fill_o     = fill;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_trng_word_collector.sv
// Bench for trng_word_collector (NBITS=8, NCH=2, DEPTH=2): directed cases
// plus random traffic against a bit-queue reference model and a word
// scoreboard drained by an independent monitor.
module tb_trng_word_collector;

  localparam int NBITS = 8;
  localparam int NCH   = 2;
  localparam int DEPTH = 2;
  localparam int FW    = $clog2(DEPTH + 1);

  logic clk;
  logic rst_i;

  trng_word_collector_if #(.NBITS(NBITS), .NCH(NCH), .DEPTH(DEPTH)) bus ();

  trng_word_collector #(.NBITS(NBITS), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: words the model says entered the FIFO, oldest first
  logic [NBITS-1:0] exp_q[$];

  // Reference model state
  bit       pend[$];
  int       m_fill;
  bit       m_ovf;
  bit       m_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model of one clock edge, described as bit-stream and queue operations
  task automatic model_edge(input bit rst, input bit en, input logic [NCH-1:0] bits,
                            input bit xm, input bit rdy);
    bit               do_pop;
    bit               have_word;
    logic [NBITS-1:0] w;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      m_fill = 0;
      m_ovf  = 0;
      m_mode = xm;
      return;
    end
    do_pop    = (m_fill > 0) && rdy;
    have_word = 0;
    w         = '0;
    if (xm != m_mode) begin
      m_mode = xm;
      pend.delete();
    end else if (en) begin
      if (m_mode) pend.push_back(^bits);
      else for (int i = NCH - 1; i >= 0; i--) pend.push_back(bits[i]);
      if (pend.size() == NBITS) begin
        // Earliest sampled bit becomes the MSB
        foreach (pend[i]) w = {w[NBITS-2:0], pend[i]};
        pend.delete();
        have_word = 1;
      end
    end
    if (have_word) begin
      if (m_fill < DEPTH || do_pop) begin
        exp_q.push_back(w);
        m_fill++;
      end else begin
        m_ovf = 1;
      end
    end
    if (do_pop) m_fill--;
  endtask

  // Driver: apply one cycle of inputs, advance the model, check state after the edge
  task automatic step(input bit rst, input bit en, input logic [NCH-1:0] bits,
                      input bit xm, input bit rdy);
    rst_i          = rst;
    bus.en_i       = en;
    bus.bits_i     = bits;
    bus.xor_mode_i = xm;
    bus.ready_i    = rdy;
    model_edge(rst, en, bits, xm, rdy);
    @(posedge clk);
    #1;
    chk("valid", 32'(bus.valid_o), 32'(m_fill > 0));
    chk("fill", 32'(bus.fill_o), 32'(m_fill));
    chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    if (m_fill == 0) chk("word_empty", 32'(bus.word_o), 32'h0);
  endtask

  // Monitor: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (!rst_i && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", 32'(bus.word_o), 32'hFFFF_FFFF);
      end else begin
        chk("sb_word", 32'(bus.word_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Stimulus and directed checks
  initial begin
    logic [NCH-1:0] t1_bits [4];
    logic [NCH-1:0] t3_bits [12];
    bit             t2_par  [8];
    bit             xm_r;

    t1_bits = '{2'b11, 2'b00, 2'b10, 2'b01};
    t2_par  = '{1, 0, 1, 1, 0, 0, 1, 0};
    t3_bits = '{2'b10, 2'b10, 2'b01, 2'b01,
                2'b00, 2'b11, 2'b11, 2'b00,
                2'b11, 2'b11, 2'b11, 2'b11};

    rst_i = 1'b1;
    bus.en_i = 1'b0;
    bus.bits_i = '0;
    bus.xor_mode_i = 1'b0;
    bus.ready_i = 1'b0;

    // Reset
    step(1, 1, 2'b11, 0, 1);
    step(1, 0, 2'b00, 0, 0);
    chk("rst_valid", 32'(bus.valid_o), 32'h0);
    chk("rst_word", 32'(bus.word_o), 32'h0);
    chk("rst_fill", 32'(bus.fill_o), 32'h0);
    chk("rst_ovf", 32'(bus.overflow_o), 32'h0);

    // Raw word C9, ready held high
    for (int i = 0; i < 4; i++) step(0, 1, t1_bits[i], 0, 1);
    chk("t1_valid", 32'(bus.valid_o), 32'h1);
    chk("t1_word", 32'(bus.word_o), 32'hC9);
    chk("t1_fill", 32'(bus.fill_o), 32'h1);
    step(0, 0, 2'b00, 0, 1);
    chk("t1_popped", 32'(bus.valid_o), 32'h0);

    // XOR-fold word B2 (odd parity pattern 01, even pattern 11)
    step(0, 0, 2'b00, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, t2_par[i] ? 2'b01 : 2'b11, 1, 1);
    chk("t2_word", 32'(bus.word_o), 32'hB2);
    step(0, 0, 2'b00, 1, 1);

    // Overflow: back to raw with a discarded sample, then A5, 3C, FF unread
    step(0, 1, 2'b11, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, t3_bits[i], 0, 0);
    chk("t3_fill", 32'(bus.fill_o), 32'h2);
    chk("t3_ovf", 32'(bus.overflow_o), 32'h1);
    chk("t3_head", 32'(bus.word_o), 32'hA5);
    step(0, 0, 2'b00, 0, 1);
    chk("t3_second", 32'(bus.word_o), 32'h3C);
    step(0, 0, 2'b00, 0, 1);
    chk("t3_drained_valid", 32'(bus.valid_o), 32'h0);
    chk("t3_drained_word", 32'(bus.word_o), 32'h0);
    chk("t3_ovf_sticky", 32'(bus.overflow_o), 32'h1);

    // Full FIFO with push and pop on the same edge
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, NCH'($urandom_range(0, 3)), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, NCH'($urandom_range(0, 3)), 0, 0);
    step(0, 1, 2'b10, 0, 1);
    chk("t4_ovf", 32'(bus.overflow_o), 32'h0);
    chk("t4_fill", 32'(bus.fill_o), 32'h2);
    step(0, 0, 2'b00, 0, 1);
    step(0, 0, 2'b00, 0, 1);
    step(0, 0, 2'b00, 0, 1);

    // Mode toggle after two raw samples, sample in the toggle cycle discarded
    step(0, 1, 2'b11, 0, 0);
    step(0, 1, 2'b11, 0, 0);
    step(0, 1, 2'b11, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, (i % 2 == 0) ? 2'b10 : 2'b00, 1, 0);
    chk("t5_word", 32'(bus.word_o), 32'hAA);

    // Reset mid-word with one word queued
    step(0, 0, 2'b00, 0, 0);
    step(0, 1, 2'b11, 0, 0);
    step(0, 1, 2'b10, 0, 0);
    step(1, 1, 2'b11, 0, 1);
    chk("t6_valid", 32'(bus.valid_o), 32'h0);
    chk("t6_word", 32'(bus.word_o), 32'h0);
    chk("t6_fill", 32'(bus.fill_o), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 2'b01, 0, 0);
    chk("t6_fresh_word", 32'(bus.word_o), 32'h55);
    step(0, 0, 2'b00, 0, 1);

    // Random traffic
    xm_r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) xm_r = ~xm_r;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           NCH'($urandom_range(0, 3)), xm_r, $urandom_range(0, 2) == 0);
    end

    // Drain and confirm nothing was left behind
    for (int i = 0; i < 6; i++) step(0, 0, 2'b00, xm_r, 1);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
